hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). Tracks in-flight
//  destination registers in a 3-entry scoreboard (EX/MEM/WB), detects load-use hazards the forwarding
//  unit cannot cover, squashes wrong-path instructions on taken branches, and freezes the whole pipe while
//  data memory is busy. Drives the stall/flush/bubble controls of the IF/ID and ID/EX pipeline registers.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles flush_id/bubble_ex stay asserted per taken branch (1..4)
//  CNT_W         16  width of the saturating performance counters
// PORTS
//  clk              in   1      core clock, rising edge
//  rst              in   1      synchronous, active-high reset
//  dec_valid        in   1      ID stage holds a valid instruction
//  dec_rs1/dec_rs2  in   5 ea   ID source register addresses
//  dec_use_rs1/2    in   1 ea   ID instruction actually reads rs1 / rs2
//  dec_rd           in   5      ID destination register
//  dec_reg_write    in   1      ID instruction writes the register file
//  dec_is_load      in   1      ID instruction is a load
//  ex_branch_taken  in   1      EX resolved a taken branch/jump this cycle
//  mem_busy         in   1      data memory not ready; MEM cannot complete
//  stall_if         out  1      hold PC
//  stall_id         out  1      hold IF/ID register
//  flush_id         out  1      clear IF/ID register to NOP
//  bubble_ex        out  1      load NOP into ID/EX register
//  freeze           out  1      hold EX/MEM and MEM/WB registers
//  stall_cnt        out  CNT_W  cycles lost to load-use + memory stalls, saturating
//  flush_cnt        out  CNT_W  taken-branch flush events, saturating
// BEHAVIOUR
//  Reset: all outputs 0, scoreboard entries invalid, FSM = RUN, counters 0. Reset mid-stall/flush
//   aborts it; first cycle after rst deassert is RUN with no pending hazards.
//  Scoreboard entry = {valid, rd, is_load}; valid only if reg_write && rd!=0.
//  Hazard conditions (combinational, evaluated every cycle):
//   MEMW: mem_busy.
//   BR:   ex_branch_taken, or FSM in FLUSH.
//   LU:   dec_valid && sb_ex.valid && sb_ex.is_load && ((dec_use_rs1 && dec_rs1==sb_ex.rd) ||
//         (dec_use_rs2 && dec_rs2==sb_ex.rd)). x0 never matches.
//  Priority MEMW > BR > LU; exactly one action per cycle:
//   MEMW: stall_if=stall_id=freeze=1, bubble_ex=flush_id=0; scoreboard holds; FSM state/count hold.
//         A branch or load-use present during MEMW is acted on in the first non-busy cycle.
//   BR:   flush_id=1, bubble_ex=1, stalls 0; LU ignored (wrong-path instruction).
//   LU:   stall_if=stall_id=1, bubble_ex=1; single cycle, since load then advances to MEM.
//   none: all controls 0.
//  Scoreboard advance (every cycle not MEMW): WB<=MEM, MEM<=EX, EX<=decode entry if dec_valid and no
//   BR/LU action, else invalid (bubble).
//  FSM RUN/FLUSH: RUN + ex_branch_taken (not MEMW) -> FLUSH if FLUSH_CYCLES>1, load down-counter with
//   FLUSH_CYCLES-1; FLUSH decrements each non-MEMW cycle, -> RUN at 1. ex_branch_taken in FLUSH
//   reloads the counter. FLUSH_CYCLES=1 never leaves RUN.
//  Counters: stall_cnt +1 per MEMW or LU cycle; flush_cnt +1 per ex_branch_taken accepted (not MEMW).
//   Both saturate at all-ones, never wrap. Counters registered: visible the cycle after the event.
//  Control outputs are combinational from inputs + state: zero-cycle latency.
// TESTING
//  lw x5 in EX, ID add x6,x5,x1 (use_rs1) -> 1 cycle stall_if=stall_id=bubble_ex=1, then 0; stall_cnt=1.
//  Same with dec_rd/dec_rs2=x5 but dec_use_rs2=0, or load rd=x0 -> no stall.
//  ex_branch_taken=1 with concurrent LU -> flush_id=bubble_ex=1, stall_if=0, flush_cnt=1; FLUSH_CYCLES=3 -> 3 cycles.
//  mem_busy 4 cycles with LU pending -> freeze 4 cycles, scoreboard unchanged, then LU stall; stall_cnt=5.
//  CNT_W=4, 20 load-use stalls -> stall_cnt stops at 15.
//  rst pulsed during FLUSH (FLUSH_CYCLES=4) -> next cycle all outputs 0, scoreboard empty, FSM RUN.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for a 5-stage core: load-use stalls, taken-branch squashes and
// data-memory freezes, driven from a 3-entry EX/MEM/WB destination scoreboard.
`timescale 1ns/1ps
module hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_reg_write,
  input  logic             dec_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_r;
  logic [FC_W-1:0] fc_cnt_r;
  sb_entry_t       sb_ex_r;
  sb_entry_t       sb_mem_r;
  sb_entry_t       sb_wb_r;
  sb_entry_t       dec_entry_s;

  logic hz_mem_s;
  logic hz_br_s;
  logic hz_lu_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic act_br_s;
  logic act_lu_s;

  // The WB entry only retires tracking state; nothing consumes it yet.
  logic unused_wb_s;
  assign unused_wb_s = ^sb_wb_r;

  // Scoreboard entry the ID instruction would occupy once it enters EX.
  always_comb begin
    dec_entry_s         = '0;
    dec_entry_s.valid   = dec_valid && dec_reg_write && (dec_rd != 5'd0);
    dec_entry_s.rd      = dec_rd;
    dec_entry_s.is_load = dec_is_load;
  end

  // Hazard detection and the single action chosen by priority MEMW > BR > LU.
  always_comb begin
    hz_mem_s  = mem_busy;
    hz_br_s   = ex_branch_taken || (state_r == FLUSH);
    rs1_hit_s = dec_use_rs1 && (dec_rs1 != 5'd0) && (dec_rs1 == sb_ex_r.rd);
    rs2_hit_s = dec_use_rs2 && (dec_rs2 != 5'd0) && (dec_rs2 == sb_ex_r.rd);
    hz_lu_s   = dec_valid && sb_ex_r.valid && sb_ex_r.is_load && (rs1_hit_s || rs2_hit_s);
    act_br_s  = !hz_mem_s && hz_br_s;
    act_lu_s  = !hz_mem_s && !hz_br_s && hz_lu_s;
  end

  // Pipeline-register controls, zero-cycle latency from the hazard decision.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    freeze    = 1'b0;
    if (rst) begin
      freeze = 1'b0;
    end else if (hz_mem_s) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      freeze   = 1'b1;
    end else if (hz_br_s) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (hz_lu_s) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      freeze = 1'b0;
    end
  end

  // Scoreboard shift; a squashed or stalled ID slot enters EX as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex_r  <= '0;
      sb_mem_r <= '0;
      sb_wb_r  <= '0;
    end else if (!hz_mem_s) begin
      sb_wb_r  <= sb_mem_r;
      sb_mem_r <= sb_ex_r;
      sb_ex_r  <= (act_br_s || act_lu_s) ? sb_entry_t'('0) : dec_entry_s;
    end
  end

  // RUN/FLUSH sequencer stretching a taken-branch squash over FLUSH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RUN;
      fc_cnt_r <= '0;
    end else if (!hz_mem_s) begin
      case (state_r)
        RUN: begin
          if (ex_branch_taken && (FLUSH_CYCLES > 1)) begin
            state_r  <= FLUSH;
            fc_cnt_r <= FC_RELOAD;
          end
        end
        FLUSH: begin
          if (ex_branch_taken) begin
            fc_cnt_r <= FC_RELOAD;
          end else if (fc_cnt_r <= FC_ONE) begin
            state_r  <= RUN;
            fc_cnt_r <= '0;
          end else begin
            fc_cnt_r <= fc_cnt_r - FC_ONE;
          end
        end
        default: begin
          state_r  <= RUN;
          fc_cnt_r <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((hz_mem_s || act_lu_s) && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (ex_branch_taken && !hz_mem_s && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: three instances (FLUSH_CYCLES 1/3/4, CNT_W 16/16/4)
// share stimulus; expected control vectors are queued at drive time and popped at the sample point.
`timescale 1ns/1ps
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic [4:0] dec_rd;
  logic       dec_reg_write;
  logic       dec_is_load;
  logic       ex_branch_taken;
  logic       mem_busy;

  // Control vector order: {stall_if, stall_id, flush_id, bubble_ex, freeze}
  wire [4:0]  ctl1;
  wire [4:0]  ctl3;
  wire [4:0]  ctl4;
  wire [15:0] scnt1, fcnt1, scnt3, fcnt3;
  wire [3:0]  scnt4, fcnt4;
  wire [14:0] ctl_all = {ctl1, ctl3, ctl4};

  localparam logic [4:0] CZ = 5'b00000;
  localparam logic [4:0] CF = 5'b00110;
  localparam logic [4:0] CL = 5'b11010;
  localparam logic [4:0] CM = 5'b11001;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
    logic       mb;
  } stim_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [14:0] exp_q[$];
  logic [14:0] exp_v;
  logic [14:0] got_v;

  hazard_controller #(.FLUSH_CYCLES(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .stall_if(ctl1[4]), .stall_id(ctl1[3]), .flush_id(ctl1[2]),
    .bubble_ex(ctl1[1]), .freeze(ctl1[0]), .stall_cnt(scnt1), .flush_cnt(fcnt1));

  hazard_controller #(.FLUSH_CYCLES(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .stall_if(ctl3[4]), .stall_id(ctl3[3]), .flush_id(ctl3[2]),
    .bubble_ex(ctl3[1]), .freeze(ctl3[0]), .stall_cnt(scnt3), .flush_cnt(fcnt3));

  hazard_controller #(.FLUSH_CYCLES(4), .CNT_W(4)) u_d4 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .stall_if(ctl4[4]), .stall_id(ctl4[3]), .flush_id(ctl4[2]),
    .bubble_ex(ctl4[1]), .freeze(ctl4[0]), .stall_cnt(scnt4), .flush_cnt(fcnt4));

  always #5 clk = ~clk;

  function automatic stim_t s_load(input logic [4:0] rd);
    stim_t s = '0;
    s.v = 1'b1; s.rd = rd; s.rw = 1'b1; s.ld = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_alu(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                  input logic u2, input logic [4:0] rd);
    stim_t s = '0;
    s.v = 1'b1; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.rd = rd; s.rw = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_br(input stim_t b);
    stim_t s = b;
    s.br = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_mb(input stim_t b);
    stim_t s = b;
    s.mb = 1'b1;
    return s;
  endfunction

  function automatic logic [14:0] all3(input logic [4:0] c);
    return {c, c, c};
  endfunction

  task automatic apply(input stim_t s);
    dec_valid = s.v; dec_rs1 = s.rs1; dec_use_rs1 = s.u1; dec_rs2 = s.rs2; dec_use_rs2 = s.u2;
    dec_rd = s.rd; dec_reg_write = s.rw; dec_is_load = s.ld;
    ex_branch_taken = s.br; mem_busy = s.mb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply('0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(15'd0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_tests++;
    if (ctl_all !== exp_v) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected %b", ctl_all, exp_v);
    end
    n_tests++;
    if ({scnt1, fcnt1, scnt3, fcnt3, scnt4, fcnt4} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h/%h/%h/%h/%h/%h expected all 0",
               scnt1, fcnt1, scnt3, fcnt3, scnt4, fcnt4);
    end
    tick();
  endtask

  task automatic test_load_use();
    stim_t st[3];
    logic [14:0] ex[3];
    do_reset();
    st = '{s_load(5'd5), s_alu(5'd5, 1'b1, 5'd1, 1'b1, 5'd6), s_alu(5'd5, 1'b1, 5'd1, 1'b1, 5'd6)};
    ex = '{all3(CZ), all3(CL), all3(CZ)};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got_v = ctl_all;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, got_v, exp_v);
      end
      tick();
    end
    n_tests++;
    if ({scnt1, scnt4} !== {16'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL load_use_cnt: got %0d/%0d expected 1/1", scnt1, scnt4);
    end
  endtask

  task automatic test_no_false_stall();
    stim_t st[8];
    stim_t hide;
    do_reset();
    hide = s_alu(5'd5, 1'b1, 5'd5, 1'b1, 5'd9);
    hide.v = 1'b0;
    st = '{s_load(5'd5), s_alu(5'd1, 1'b1, 5'd5, 1'b0, 5'd5),
           s_load(5'd0), s_alu(5'd0, 1'b1, 5'd0, 1'b1, 5'd7),
           s_alu(5'd1, 1'b1, 5'd2, 1'b1, 5'd5), s_alu(5'd5, 1'b1, 5'd5, 1'b1, 5'd8),
           s_load(5'd5), hide};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      exp_q.push_back(all3(CZ));
      @(negedge clk);
      got_v = ctl_all;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL no_false_stall[%0d]: got %b expected %b", i, got_v, exp_v);
      end
      tick();
    end
    n_tests++;
    if (scnt1 !== 16'd0) begin
      n_fail++;
      $display("FAIL no_false_stall_cnt: got %0d expected 0", scnt1);
    end
  endtask

  task automatic test_branch();
    stim_t st[6];
    logic [14:0] ex[6];
    do_reset();
    st = '{s_load(5'd5), s_br(s_alu(5'd5, 1'b1, 5'd1, 1'b1, 5'd6)), '0, '0, '0, '0};
    ex = '{all3(CZ), all3(CF), {CZ, CF, CF}, {CZ, CF, CF}, {CZ, CZ, CF}, all3(CZ)};
    for (int i = 0; i < 6; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got_v = ctl_all;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL branch[%0d]: got %b expected %b", i, got_v, exp_v);
      end
      tick();
    end
    n_tests++;
    if ({fcnt1, fcnt3, fcnt4, scnt1} !== {16'd1, 16'd1, 4'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL branch_cnt: got flush %0d/%0d/%0d stall %0d expected 1/1/1 stall 0",
               fcnt1, fcnt3, fcnt4, scnt1);
    end
  endtask

  task automatic test_mem_busy();
    stim_t use5;
    do_reset();
    use5 = s_alu(5'd5, 1'b1, 5'd1, 1'b1, 5'd6);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        apply(s_load(5'd5));
        exp_q.push_back(all3(CZ));
      end else if (i < 5) begin
        apply(s_mb(use5));
        exp_q.push_back(all3(CM));
      end else if (i == 5) begin
        apply(use5);
        exp_q.push_back(all3(CL));
      end else begin
        apply(use5);
        exp_q.push_back(all3(CZ));
      end
      @(negedge clk);
      got_v = ctl_all;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL mem_busy[%0d]: got %b expected %b", i, got_v, exp_v);
      end
      tick();
    end
    n_tests++;
    if ({scnt1, scnt4} !== {16'd5, 4'd5}) begin
      n_fail++;
      $display("FAIL mem_busy_cnt: got %0d/%0d expected 5/5", scnt1, scnt4);
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[18];
    logic [14:0] ex[18];
    stim_t b;
    do_reset();
    b = s_br('0);
    st = '{b, b, '0, '0, '0, '0,
           b, s_mb('0), '0, '0, '0, '0,
           s_mb(b), b, '0, '0, '0, '0};
    ex = '{all3(CF), all3(CF), {CZ, CF, CF}, {CZ, CF, CF}, {CZ, CZ, CF}, all3(CZ),
           all3(CF), all3(CM), {CZ, CF, CF}, {CZ, CF, CF}, {CZ, CZ, CF}, all3(CZ),
           all3(CM), all3(CF), {CZ, CF, CF}, {CZ, CF, CF}, {CZ, CZ, CF}, all3(CZ)};
    for (int i = 0; i < 18; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got_v = ctl_all;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, got_v, exp_v);
      end
      tick();
    end
    n_tests++;
    if ({fcnt1, fcnt3, fcnt4, scnt1} !== {16'd4, 16'd4, 4'd4, 16'd2}) begin
      n_fail++;
      $display("FAIL back_to_back_cnt: got flush %0d/%0d/%0d stall %0d expected 4/4/4 stall 2",
               fcnt1, fcnt3, fcnt4, scnt1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      apply(s_load(5'd5));
      exp_q.push_back(all3(CZ));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (ctl_all !== exp_v) begin
        n_fail++;
        $display("FAIL sat_load[%0d]: got %b expected %b", k, ctl_all, exp_v);
      end
      tick();
      apply(s_alu(5'd2, 1'b1, 5'd5, 1'b1, 5'd6));
      exp_q.push_back(all3(CL));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (ctl_all !== exp_v) begin
        n_fail++;
        $display("FAIL sat_use[%0d]: got %b expected %b", k, ctl_all, exp_v);
      end
      tick();
      if (k == 14) begin
        n_tests++;
        if (scnt4 !== 4'd15) begin
          n_fail++;
          $display("FAIL sat_at_max: got %0d expected 15", scnt4);
        end
      end
    end
    n_tests++;
    if ({scnt1, scnt4} !== {16'd20, 4'd15}) begin
      n_fail++;
      $display("FAIL sat_final: got %0d/%0d expected 20/15", scnt1, scnt4);
    end
  endtask

  task automatic test_reset_in_flush();
    stim_t st[3];
    logic [14:0] ex[3];
    do_reset();
    st = '{s_load(5'd5), s_br('0), '0};
    ex = '{all3(CZ), all3(CF), {CZ, CF, CF}};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got_v = ctl_all;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL rst_flush_pre[%0d]: got %b expected %b", i, got_v, exp_v);
      end
      tick();
    end
    rst = 1'b1;
    apply(s_load(5'd5));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply((i == 0) ? s_alu(5'd5, 1'b1, 5'd5, 1'b1, 5'd6) : stim_t'('0));
      exp_q.push_back(all3(CZ));
      @(negedge clk);
      got_v = ctl_all;
      exp_v = exp_q.pop_front();
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL rst_flush_post[%0d]: got %b expected %b", i, got_v, exp_v);
      end
      tick();
    end
    n_tests++;
    if ({scnt1, fcnt1, scnt3, fcnt3, scnt4, fcnt4} !== 72'd0) begin
      n_fail++;
      $display("FAIL rst_flush_cnt: got %0d/%0d/%0d/%0d/%0d/%0d expected all 0",
               scnt1, fcnt1, scnt3, fcnt3, scnt4, fcnt4);
    end
  endtask

  initial begin
    rst = 1'b1;
    apply('0);
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch();
    test_mem_busy();
    test_back_to_back();
    test_saturation();
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
